// File: rtl/ddr_rd_arbiter.sv
// rtl/ddr_rd_arbiter.sv - round-robin DDR read address arbiter with in-order data steering
module ddr_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 8,
    parameter int DDR_W      = 512,
    parameter int MAX_OUTST  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ*DDR_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*BURST_W-1:0]      req_size,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [DDR_ADDR_W-1:0]           ddr_addr,
    output logic [BURST_W-1:0]              ddr_size,
    output logic                            ddr_addr_valid,
    input  logic                            ddr_addr_ready,
    input  logic [DDR_W-1:0]                ddr_data,
    input  logic                            ddr_valid,
    output logic                            ddr_ready,
    output logic [DDR_W-1:0]                rsp_data,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic                            rsp_last,
    output logic [$clog2(MAX_OUTST):0]      outst_cnt,
    output logic                            busy
);

    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               load;
    logic               grant;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [BURST_W-1:0] beat_cnt;
    logic [ID_W-1:0]    id_mem   [MAX_OUTST];
    logic [BURST_W-1:0] size_mem [MAX_OUTST];
    logic [ID_W-1:0]    head_id;
    logic [BURST_W-1:0] head_size;
    logic               fifo_empty;
    logic               beat_xfer;
    logic               pop;

    // Scan from highest k down so the lowest offset from rr_ptr wins.
    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    assign load      = (!ddr_addr_valid || ddr_addr_ready) && (outst_cnt < CNT_W'(MAX_OUTST));
    assign grant     = rst && load && found;
    assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

    assign fifo_empty = (outst_cnt == '0);
    assign head_id    = id_mem[rd_ptr];
    assign head_size  = size_mem[rd_ptr];
    assign rsp_data   = ddr_data;

    // Handshakes are held off while reset is asserted so no beat is claimed then lost.
    always_comb begin
        rsp_valid = '0;
        ddr_ready = 1'b0;
        rsp_last  = 1'b0;
        if (rst && !fifo_empty) begin
            rsp_valid[head_id] = ddr_valid;
            ddr_ready          = rsp_ready[head_id];
            rsp_last           = (beat_cnt == head_size - 1'b1);
        end
    end

    assign beat_xfer = ddr_valid && ddr_ready;
    assign pop       = beat_xfer && rsp_last;
    assign busy      = (outst_cnt != '0) || ddr_addr_valid;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ddr_addr_valid <= 1'b0;
            ddr_addr       <= '0;
            ddr_size       <= '0;
            outst_cnt      <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            beat_cnt       <= '0;
            rr_ptr         <= '0;
        end else begin
            if (grant) begin
                ddr_addr_valid <= 1'b1;
                ddr_addr       <= req_addr[int'(winner)*DDR_ADDR_W +: DDR_ADDR_W];
                ddr_size       <= req_size[int'(winner)*BURST_W +: BURST_W];
                wr_ptr         <= wr_ptr + 1'b1;
                rr_ptr         <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            end else if (ddr_addr_ready) begin
                ddr_addr_valid <= 1'b0;
            end
            if (beat_xfer) begin
                beat_cnt <= pop ? '0 : beat_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({grant, pop})
                2'b10:   outst_cnt <= outst_cnt + 1'b1;
                2'b01:   outst_cnt <= outst_cnt - 1'b1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    // ID/size storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (grant) begin
            id_mem[wr_ptr]   <= winner;
            size_mem[wr_ptr] <= req_size[int'(winner)*BURST_W +: BURST_W];
        end
    end

endmodule

// File: tb/tb_ddr_rd_arbiter.sv
// tb/tb_ddr_rd_arbiter.sv - randomized scoreboard bench for ddr_rd_arbiter
module tb_ddr_rd_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int BW = 8;
    localparam int DW = 512;
    localparam int MO = 8;

    logic             clk;
    logic             rst;
    logic [NR*AW-1:0] req_addr;
    logic [NR*BW-1:0] req_size;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    req_ready;
    logic [AW-1:0]    ddr_addr;
    logic [BW-1:0]    ddr_size;
    logic             ddr_addr_valid;
    logic             ddr_addr_ready;
    logic [DW-1:0]    ddr_data;
    logic             ddr_valid;
    logic             ddr_ready;
    logic [DW-1:0]    rsp_data;
    logic [NR-1:0]    rsp_valid;
    logic [NR-1:0]    rsp_ready;
    logic             rsp_last;
    logic [3:0]       outst_cnt;
    logic             busy;

    ddr_rd_arbiter #(
        .NUM_REQ(NR), .DDR_ADDR_W(AW), .BURST_W(BW), .DDR_W(DW), .MAX_OUTST(MO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_size(req_size), .req_valid(req_valid), .req_ready(req_ready),
        .ddr_addr(ddr_addr), .ddr_size(ddr_size), .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready), .ddr_data(ddr_data), .ddr_valid(ddr_valid),
        .ddr_ready(ddr_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_last(rsp_last), .outst_cnt(outst_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int id;
        int size;
    } burst_t;

    burst_t        q[$];
    int            rr;
    int            beat;
    bit            m_av;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_size;

    always @(posedge clk) begin
        for (int i = 0; i < NR; i++)
            if (rst && req_valid[i]) assert (req_size[i*BW +: BW] != 0);
    end

    task automatic model_reset();
        q.delete();
        rr     = 0;
        beat   = 0;
        m_av   = 1'b0;
        m_addr = '0;
        m_size = '0;
    endtask

    task automatic drive(input bit allow_data);
        for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                req_valid[i]          = 1'b1;
                req_addr[i*AW +: AW]  = $urandom;
                req_size[i*BW +: BW]  = BW'($urandom_range(1, 5));
            end
            rsp_ready[i] = ($urandom_range(0, 3) != 0);
        end
        ddr_addr_ready = ($urandom_range(0, 3) != 0);
        ddr_valid      = allow_data && ($urandom_range(0, 2) != 0);
        for (int c = 0; c < DW / 32; c++) ddr_data[c*32 +: 32] = $urandom;
    endtask

    // Checks outputs at the falling edge, advances the model, then steps past the rising edge.
    task automatic cycle(input bit rst_v);
        bit            load;
        int            w;
        int            idx;
        logic [NR-1:0] e_rr;
        logic [NR-1:0] e_rv;
        bit            e_dr;
        bit            e_last;
        rst = rst_v;
        @(negedge clk);
        load = (!m_av || ddr_addr_ready) && (q.size() < MO);
        w = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (rr + k) % NR;
            if (w < 0 && req_valid[idx]) w = idx;
        end
        e_rr   = (rst_v && load && w >= 0) ? NR'(1 << w) : '0;
        e_rv   = '0;
        e_dr   = 1'b0;
        e_last = 1'b0;
        if (rst_v && q.size() > 0) begin
            e_rv[q[0].id] = ddr_valid;
            e_dr          = rsp_ready[q[0].id];
            e_last        = (beat == q[0].size - 1);
        end
        check("req_ready",      DW'(req_ready),      DW'(e_rr));
        check("ddr_addr_valid", DW'(ddr_addr_valid), DW'(m_av));
        check("ddr_addr",       DW'(ddr_addr),       DW'(m_addr));
        check("ddr_size",       DW'(ddr_size),       DW'(m_size));
        check("rsp_valid",      DW'(rsp_valid),      DW'(e_rv));
        check("ddr_ready",      DW'(ddr_ready),      DW'(e_dr));
        check("rsp_last",       DW'(rsp_last),       DW'(e_last));
        check("outst_cnt",      DW'(outst_cnt),      DW'(q.size()));
        check("busy",           DW'(busy),           DW'(q.size() != 0 || m_av));
        check("rsp_data",       rsp_data,            ddr_data);
        if (!rst_v) begin
            model_reset();
        end else begin
            if (ddr_valid && e_dr) begin
                beat++;
                if (beat == q[0].size) begin
                    void'(q.pop_front());
                    beat = 0;
                end
            end
            if (e_rr != '0) begin
                q.push_back('{w, int'(req_size[w*BW +: BW])});
                m_av   = 1'b1;
                m_addr = req_addr[w*AW +: AW];
                m_size = req_size[w*BW +: BW];
                rr     = (w + 1) % NR;
            end else if (ddr_addr_ready) begin
                m_av = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (e_rr[i]) req_valid[i] = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        req_valid      = '1;
        req_addr       = '0;
        req_size       = {NR{BW'(1)}};
        rsp_ready      = '0;
        ddr_addr_ready = 1'b0;
        ddr_valid      = 1'b0;
        ddr_data       = '0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(1'b0);
        for (int n = 0; n < 3000; n++) begin
            drive((n % 600) >= 80);
            cycle(!((n % 700) == 350 || $urandom_range(0, 499) == 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
